// File: rtl/palette_pkg.sv
// Shared types and reset-time palette contents for the indexed-colour render pipe.
package palette_pkg;

  typedef logic [11:0] rgb12_t;

  // Per-pixel sideband that travels alongside the memory read.
  typedef struct packed {
    logic in_range;
    logic blank;
    logic hs;
    logic vs;
  } side_t;

  localparam side_t SIDE_RST = '{in_range: 1'b0, blank: 1'b0, hs: 1'b1, vs: 1'b1};

  localparam rgb12_t DEFAULT_PAL [8] = '{
    12'h320, 12'hA75, 12'h888, 12'hCB9,
    12'h631, 12'h111, 12'h443, 12'hFFF
  };

  function automatic rgb12_t default_entry(input int i);
    if (i >= 0 && i < 8) return DEFAULT_PAL[i[2:0]];
    return 12'h000;
  endfunction

endpackage

// File: rtl/palette_regfile.sv
// Runtime-writable colour palette with a combinational read port.
module palette_regfile
  import palette_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  rgb12_t           wdata,
  input  logic [IDX_W-1:0] raddr,
  output rgb12_t           rdata
);

  localparam int DEPTH = 2**IDX_W;

  rgb12_t pal_r [DEPTH];

  // Reset has priority so a write strobe during reset cannot stick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) pal_r[i] <= default_entry(i);
    end else if (we) begin
      pal_r[waddr] <= wdata;
    end
  end

  assign rdata = pal_r[raddr];

endmodule

// File: rtl/palette_render_pipe.sv
// Screen coordinate -> framebuffer address -> palette colour pipeline, with
// blank/sync delayed to stay aligned with the RGB output (MEM_LAT+2 clocks).
module palette_render_pipe
  import palette_pkg::*;
#(
  parameter int FB_W       = 640,
  parameter int FB_H       = 480,
  parameter int SCALE_LOG2 = 0,
  parameter int IDX_W      = 3,
  parameter int ADDR_W     = 19,
  parameter int MEM_LAT    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              blank_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [IDX_W-1:0]  mem_q,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              blank_out,
  output logic              hs_out,
  output logic              vs_out
);

  localparam int AW1 = ADDR_W + 1;

  logic [9:0]     sx, sy;
  logic [AW1-1:0] addr_full;
  logic           fits;
  side_t          s0_q;
  side_t          tail;
  rgb12_t         pal_rdata;

  assign sx        = drawX >> SCALE_LOG2;
  assign sy        = drawY >> SCALE_LOG2;
  assign addr_full = AW1'(sx) + AW1'(FB_W) * AW1'(sy);
  // An address needing the guard bit is treated as off-screen rather than wrapped.
  assign fits      = ({1'b0, sx} < 11'(FB_W)) && ({1'b0, sy} < 11'(FB_H)) && !addr_full[ADDR_W];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s0_q     <= SIDE_RST;
      mem_addr <= '0;
    end else begin
      s0_q     <= '{in_range: fits, blank: blank_in, hs: hs_in, vs: vs_in};
      mem_addr <= fits ? addr_full[ADDR_W-1:0] : '0;
    end
  end

  for (genvar k = 0; k < MEM_LAT; k++) begin : g_dly
    side_t d, q;
    if (k == 0) begin : g_head
      assign d = s0_q;
    end else begin : g_link
      assign d = g_dly[k-1].q;
    end
    always_ff @(posedge Clk) begin
      if (Reset) q <= SIDE_RST;
      else       q <= d;
    end
  end

  assign tail = g_dly[MEM_LAT-1].q;

  palette_regfile #(.IDX_W(IDX_W)) u_pal (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (pal_we),
    .waddr (pal_waddr),
    .wdata (pal_wdata),
    .raddr (mem_q),
    .rdata (pal_rdata)
  );

  // Gating on the delayed in_range keeps stale mem_q off screen after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {red, green, blue} <= 12'h000;
      blank_out          <= SIDE_RST.blank;
      hs_out             <= SIDE_RST.hs;
      vs_out             <= SIDE_RST.vs;
    end else begin
      {red, green, blue} <= (tail.blank && tail.in_range) ? pal_rdata : 12'h000;
      blank_out          <= tail.blank;
      hs_out             <= tail.hs;
      vs_out             <= tail.vs;
    end
  end

endmodule

// File: tb/tb_palette_render_pipe.sv
// Scoreboard bench: three pipe configurations (default, 2x scaled, MEM_LAT=3)
// driven by one directed vector stream with hand-computed expectations.
module tb_palette_render_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  dx, dy;
  logic        bl, hs, vs, we;
  logic [2:0]  wa;
  logic [11:0] wd;

  logic [18:0] addr_a, addr_b, addr_c;
  logic [2:0]  q_a = 3'd0, q_b = 3'd0, q_c = 3'd0, c1 = 3'd0, c2 = 3'd0;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic        bo_a, ho_a, vo_a, bo_b, ho_b, vo_b, bo_c, ho_c, vo_c;

  palette_render_pipe u_a (
    .Clk(clk), .Reset(rst), .drawX(dx), .drawY(dy), .blank_in(bl), .hs_in(hs), .vs_in(vs),
    .mem_addr(addr_a), .mem_q(q_a), .pal_we(we), .pal_waddr(wa), .pal_wdata(wd),
    .red(r_a), .green(g_a), .blue(b_a), .blank_out(bo_a), .hs_out(ho_a), .vs_out(vo_a));

  palette_render_pipe #(.FB_W(320), .FB_H(240), .SCALE_LOG2(1)) u_b (
    .Clk(clk), .Reset(rst), .drawX(dx), .drawY(dy), .blank_in(bl), .hs_in(hs), .vs_in(vs),
    .mem_addr(addr_b), .mem_q(q_b), .pal_we(we), .pal_waddr(wa), .pal_wdata(wd),
    .red(r_b), .green(g_b), .blue(b_b), .blank_out(bo_b), .hs_out(ho_b), .vs_out(vo_b));

  palette_render_pipe #(.MEM_LAT(3)) u_c (
    .Clk(clk), .Reset(rst), .drawX(dx), .drawY(dy), .blank_in(bl), .hs_in(hs), .vs_in(vs),
    .mem_addr(addr_c), .mem_q(q_c), .pal_we(we), .pal_waddr(wa), .pal_wdata(wd),
    .red(r_c), .green(g_c), .blue(b_c), .blank_out(bo_c), .hs_out(ho_c), .vs_out(vo_c));

  // Framebuffer contents: index = (addr + 6) mod 8.
  function automatic logic [2:0] idx_of(input logic [18:0] a);
    logic [18:0] s;
    s = a + 19'd6;
    return s[2:0];
  endfunction

  always @(posedge clk) begin
    q_a <= idx_of(addr_a);
    q_b <= idx_of(addr_b);
    c1  <= idx_of(addr_c);
    c2  <= c1;
    q_c <= c2;
  end

  typedef struct { int due; logic [11:0] rgb; logic bl; logic hs; logic vs; } pix_t;
  typedef struct { int due; logic [18:0] addr; } adr_t;

  pix_t pq_a[$], pq_b[$], pq_c[$];
  adr_t aq_a[$], aq_b[$], aq_c[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic pix_t rst_pix(input int due);
    return pix_t'{due: due, rgb: 12'h000, bl: 1'b0, hs: 1'b1, vs: 1'b1};
  endfunction

  task automatic chk_pix(input string nm, input pix_t e, input logic [11:0] rgb,
                         input logic b, input logic h, input logic v);
    checks++;
    if (rgb !== e.rgb || b !== e.bl || h !== e.hs || v !== e.vs) begin
      failures++;
      $display("FAIL %s cyc=%0d got rgb=%h blank=%b hs=%b vs=%b expected rgb=%h blank=%b hs=%b vs=%b",
               nm, cyc, rgb, b, h, v, e.rgb, e.bl, e.hs, e.vs);
    end
  endtask

  task automatic chk_adr(input string nm, input adr_t e, input logic [18:0] a);
    checks++;
    if (a !== e.addr) begin
      failures++;
      $display("FAIL %s cyc=%0d got mem_addr=%0d expected %0d", nm, cyc, a, e.addr);
    end
  endtask

  // Monitor: compare whatever is due at this falling edge.
  always @(negedge clk) begin
    while (pq_a.size() > 0 && pq_a[0].due <= cyc) chk_pix("pix_a", pq_a.pop_front(), {r_a, g_a, b_a}, bo_a, ho_a, vo_a);
    while (pq_b.size() > 0 && pq_b[0].due <= cyc) chk_pix("pix_b", pq_b.pop_front(), {r_b, g_b, b_b}, bo_b, ho_b, vo_b);
    while (pq_c.size() > 0 && pq_c[0].due <= cyc) chk_pix("pix_c", pq_c.pop_front(), {r_c, g_c, b_c}, bo_c, ho_c, vo_c);
    while (aq_a.size() > 0 && aq_a[0].due <= cyc) chk_adr("addr_a", aq_a.pop_front(), addr_a);
    while (aq_b.size() > 0 && aq_b[0].due <= cyc) chk_adr("addr_b", aq_b.pop_front(), addr_b);
    while (aq_c.size() > 0 && aq_c[0].due <= cyc) chk_adr("addr_c", aq_c.pop_front(), addr_c);
  end

  // One input vector per clock; expectations are due LAT (3/3/5) clocks later.
  task automatic issue(input logic r, input int x, input int y, input logic b, input logic h,
                       input logic v, input logic w, input logic [11:0] wdat,
                       input int ea, input int eb,
                       input logic [11:0] ra, input logic [11:0] rb, input logic [11:0] rc);
    rst = r; dx = 10'(x); dy = 10'(y); bl = b; hs = h; vs = v;
    we = w; wa = 3'd2; wd = wdat;
    if (r) begin
      for (int i = 0; i < pq_a.size(); i++) if (pq_a[i].due > cyc) pq_a[i] = rst_pix(pq_a[i].due);
      for (int i = 0; i < pq_b.size(); i++) if (pq_b[i].due > cyc) pq_b[i] = rst_pix(pq_b[i].due);
      for (int i = 0; i < pq_c.size(); i++) if (pq_c[i].due > cyc) pq_c[i] = rst_pix(pq_c[i].due);
      pq_a.push_back(rst_pix(cyc + 3));
      pq_b.push_back(rst_pix(cyc + 3));
      pq_c.push_back(rst_pix(cyc + 5));
      aq_a.push_back(adr_t'{due: cyc + 1, addr: 19'd0});
      aq_b.push_back(adr_t'{due: cyc + 1, addr: 19'd0});
      aq_c.push_back(adr_t'{due: cyc + 1, addr: 19'd0});
    end else begin
      pq_a.push_back(pix_t'{due: cyc + 3, rgb: ra, bl: b, hs: h, vs: v});
      pq_b.push_back(pix_t'{due: cyc + 3, rgb: rb, bl: b, hs: h, vs: v});
      pq_c.push_back(pix_t'{due: cyc + 5, rgb: rc, bl: b, hs: h, vs: v});
      aq_a.push_back(adr_t'{due: cyc + 1, addr: 19'(ea)});
      aq_b.push_back(adr_t'{due: cyc + 1, addr: 19'(eb)});
      aq_c.push_back(adr_t'{due: cyc + 1, addr: 19'(ea)});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    issue(0, 1023, 1023, 0, 1, 1, 0, 12'h000, 0, 0, 12'h000, 12'h000, 12'h000);
  endtask

  function automatic int pending();
    return pq_a.size() + pq_b.size() + pq_c.size() + aq_a.size() + aq_b.size() + aq_c.size();
  endfunction

  initial begin
    rst = 1'b1; dx = '0; dy = '0; bl = 1'b0; hs = 1'b1; vs = 1'b1;
    we = 1'b0; wa = 3'd2; wd = 12'h000;
    @(negedge clk);
    // reset with live inputs and a palette write that must be ignored
    issue(1, 5, 2, 1, 0, 0, 1, 12'hF00, 0, 0, 12'h000, 12'h000, 12'h000);
    issue(1, 5, 2, 1, 0, 0, 1, 12'hF00, 0, 0, 12'h000, 12'h000, 12'h000);
    //     r  x    y    b  h  v  we wdata     addrA   addrB  rgbA     rgbB     rgbC
    issue(0, 5,   2,   1, 1, 1, 0, 12'h000, 1285,   322,   12'hCB9, 12'h320, 12'hCB9);
    issue(0, 7,   9,   1, 1, 1, 0, 12'h000, 5767,   1283,  12'h111, 12'hA75, 12'h111);
    issue(0, 5,   2,   0, 1, 1, 0, 12'h000, 1285,   322,   12'h000, 12'h000, 12'h000);
    issue(0, 700, 2,   1, 1, 1, 0, 12'h000, 0,      0,     12'h000, 12'h000, 12'h000);
    issue(0, 1023,1023,1, 1, 1, 0, 12'h000, 0,      0,     12'h000, 12'h000, 12'h000);
    issue(0, 5,   2,   0, 0, 1, 0, 12'h000, 1285,   322,   12'h000, 12'h000, 12'h000);
    issue(0, 0,   0,   0, 1, 0, 0, 12'h000, 0,      0,     12'h000, 12'h000, 12'h000);
    issue(0, 100, 400, 1, 1, 1, 0, 12'h000, 256100, 64050, 12'h888, 12'h320, 12'h888);
    issue(0, 639, 479, 1, 1, 1, 0, 12'h000, 307199, 76799, 12'h111, 12'h111, 12'h111);
    issue(0, 640, 0,   1, 1, 1, 0, 12'h000, 0,      0,     12'h000, 12'h000, 12'h000);
    issue(0, 0,   480, 1, 1, 1, 0, 12'h000, 0,      0,     12'h000, 12'h000, 12'h000);
    // write entry 2 while the first idx-2 pixel of config A is at the lookup stage
    issue(0, 4,   0,   1, 1, 1, 0, 12'h000, 4,      2,     12'h888, 12'h320, 12'hF00);
    issue(0, 12,  0,   1, 1, 1, 0, 12'h000, 12,     6,     12'hF00, 12'h631, 12'hF00);
    issue(0, 20,  0,   1, 1, 1, 1, 12'hF00, 20,     10,    12'hF00, 12'h320, 12'hF00);
    idle(); idle(); idle();
    // mid-line reset: in-flight pixel flushed, palette reverts, write during reset ignored
    issue(0, 4,   0,   1, 1, 1, 0, 12'h000, 4,      2,     12'hF00, 12'h320, 12'hF00);
    issue(1, 12,  0,   1, 0, 0, 1, 12'h0F0, 0,      0,     12'h000, 12'h000, 12'h000);
    issue(1, 12,  0,   1, 0, 0, 1, 12'h0F0, 0,      0,     12'h000, 12'h000, 12'h000);
    issue(0, 4,   0,   1, 1, 1, 0, 12'h000, 4,      2,     12'h888, 12'h320, 12'h888);
    issue(0, 5,   2,   1, 1, 1, 0, 12'h000, 1285,   322,   12'hCB9, 12'h320, 12'hCB9);
    idle(); idle();
    rst = 1'b0; dx = 10'd1023; dy = 10'd1023; bl = 1'b0; hs = 1'b1; vs = 1'b1; we = 1'b0;
    for (int i = 0; i < 20 && pending() > 0; i++) @(negedge clk);
    if (pending() > 0) begin
      failures++;
      $display("FAIL drain got %0d pending expectations expected 0", pending());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
